// File: rtl/nbit_processor.sv
// nbit_processor: four-accumulator fetch/execute processor with parametrised data and PC widths.
// Define NBITPROC_IRQ_EN to compile in the single-level interrupt (IRQ state, shadow_pc, EI/DI/RETI).
module nbit_processor #(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned PC_W    = 4,
    parameter int unsigned IRQ_VEC = 32'hC
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [DATA_W+5:0] imem_data,
    input  logic              irq,
    output logic              irq_ack,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [3:0]        flags,
    output logic              halted
);
    localparam int unsigned INSN_W = DATA_W + 6;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_ADDR = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JC   = 4'hB;
    localparam logic [3:0] OP_OUT  = 4'hC;
`ifdef NBITPROC_IRQ_EN
    localparam logic [3:0] OP_EIDI = 4'hD;
    localparam logic [3:0] OP_RETI = 4'hE;
`endif
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_IRQ, ST_HALT} state_t;

    state_t              state, state_nxt;
    logic [PC_W-1:0]     pc, pc_nxt;
    logic [INSN_W-1:0]   ir, ir_nxt;
    logic [DATA_W-1:0]   acc [4];
    logic [DATA_W-1:0]   acc_nxt [4];
    logic                ie, ie_nxt, n, n_nxt, c, c_nxt, z, z_nxt;
    logic [DATA_W-1:0]   out_data_nxt;
    logic                out_valid_nxt, irq_ack_nxt;
    logic                irq_take;

    logic [3:0]          op;
    logic [1:0]          rsel;
    logic [DATA_W-1:0]   imm, a, b;
    logic [PC_W-1:0]     imm_pc, pc_inc;

    logic [DATA_W-1:0]   alu_res;
    logic [DATA_W:0]     alu_sum;
    logic                alu_c, alu_wr;

    assign op        = ir[INSN_W-1 -: 4];
    assign rsel      = ir[DATA_W +: 2];
    assign imm       = ir[DATA_W-1:0];
    assign imm_pc    = imm[PC_W-1:0];
    assign a         = acc[rsel];
    assign b         = acc[imm[1:0]];
    assign pc_inc    = pc + PC_W'(1);
    assign imem_addr = pc;
    assign flags     = {ie, n, c, z};

`ifdef NBITPROC_IRQ_EN
    logic [PC_W-1:0] shadow_pc, shadow_nxt;
    assign irq_take = ie & irq;
`else
    logic unused_irq;
    assign unused_irq = irq;
    assign irq_take   = 1'b0;
`endif

    // ALU: result, carry/borrow and whether the accumulator and Z/N are written
    always_comb begin
        alu_res = a;
        alu_sum = '0;
        alu_c   = c;
        alu_wr  = 1'b0;
        case (op)
            OP_LDI:  begin alu_res = imm; alu_wr = 1'b1; end
            OP_ADD:  begin
                alu_sum = {1'b0, a} + {1'b0, imm};
                alu_res = alu_sum[DATA_W-1:0];
                alu_c   = alu_sum[DATA_W];
                alu_wr  = 1'b1;
            end
            OP_SUB:  begin
                // MSB of the widened difference is the borrow (a < imm)
                alu_sum = {1'b0, a} - {1'b0, imm};
                alu_res = alu_sum[DATA_W-1:0];
                alu_c   = alu_sum[DATA_W];
                alu_wr  = 1'b1;
            end
            OP_AND:  begin alu_res = a & imm; alu_c = 1'b0; alu_wr = 1'b1; end
            OP_OR:   begin alu_res = a | imm; alu_c = 1'b0; alu_wr = 1'b1; end
            OP_XOR:  begin alu_res = a ^ imm; alu_c = 1'b0; alu_wr = 1'b1; end
            OP_MOV:  begin alu_res = b; alu_wr = 1'b1; end
            OP_ADDR: begin
                alu_sum = {1'b0, a} + {1'b0, b};
                alu_res = alu_sum[DATA_W-1:0];
                alu_c   = alu_sum[DATA_W];
                alu_wr  = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state and next-register values
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        ir_nxt        = ir;
        acc_nxt       = acc;
        ie_nxt        = ie;
        n_nxt         = n;
        c_nxt         = c;
        z_nxt         = z;
        out_data_nxt  = out_data;
        out_valid_nxt = 1'b0;
        irq_ack_nxt   = 1'b0;
`ifdef NBITPROC_IRQ_EN
        shadow_nxt    = shadow_pc;
`endif
        case (state)
            ST_FETCH: begin
                if (irq_take) begin
                    state_nxt = ST_IRQ;
                end else begin
                    ir_nxt    = imem_data;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_nxt = ST_FETCH;
                pc_nxt    = pc_inc;
                if (alu_wr) begin
                    acc_nxt[rsel] = alu_res;
                    c_nxt         = alu_c;
                    z_nxt         = (alu_res == '0);
                    n_nxt         = alu_res[DATA_W-1];
                end
                case (op)
                    OP_JMP:  pc_nxt = imm_pc;
                    OP_JZ:   if (z) pc_nxt = imm_pc;
                    OP_JC:   if (c) pc_nxt = imm_pc;
                    OP_OUT:  begin out_data_nxt = a; out_valid_nxt = 1'b1; end
`ifdef NBITPROC_IRQ_EN
                    OP_EIDI: ie_nxt = imm[0];
                    OP_RETI: begin pc_nxt = shadow_pc; ie_nxt = 1'b1; end
`endif
                    OP_HLT:  begin pc_nxt = pc; state_nxt = ST_HALT; end
                    default: ;
                endcase
            end
            ST_IRQ: begin
`ifdef NBITPROC_IRQ_EN
                shadow_nxt  = pc;
                pc_nxt      = PC_W'(IRQ_VEC);
                ie_nxt      = 1'b0;
                irq_ack_nxt = 1'b1;
`endif
                state_nxt   = ST_FETCH;
            end
            ST_HALT: begin
                // PC still points at the HLT; the return address is the one after it
                if (irq_take) begin
                    pc_nxt    = pc_inc;
                    state_nxt = ST_IRQ;
                end
            end
            default: state_nxt = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_FETCH;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= '0;
            ir        <= '0;
            for (int i = 0; i < 4; i++) acc[i] <= '0;
            ie        <= 1'b0;
            n         <= 1'b0;
            c         <= 1'b0;
            z         <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            irq_ack   <= 1'b0;
            halted    <= 1'b0;
`ifdef NBITPROC_IRQ_EN
            shadow_pc <= '0;
`endif
        end else begin
            pc        <= pc_nxt;
            ir        <= ir_nxt;
            acc       <= acc_nxt;
            ie        <= ie_nxt;
            n         <= n_nxt;
            c         <= c_nxt;
            z         <= z_nxt;
            out_data  <= out_data_nxt;
            out_valid <= out_valid_nxt;
            irq_ack   <= irq_ack_nxt;
            halted    <= (state_nxt == ST_HALT);
`ifdef NBITPROC_IRQ_EN
            shadow_pc <= shadow_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_nbit_processor.sv
// Directed bench for nbit_processor (DATA_W=4, PC_W=4): cycle-exact checks plus an OUT scoreboard.
module tb_nbit_processor;
    logic       clk;
    logic       rst_n;
    logic [3:0] imem_addr;
    logic [9:0] imem_data;
    logic       irq;
    logic       irq_ack;
    logic [3:0] out_data;
    logic       out_valid;
    logic [3:0] flags;
    logic       halted;

    logic [9:0] rom [16];
    logic [3:0] sb [$];
    logic [3:0] sb_exp;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_fail   = 0;

    nbit_processor #(.DATA_W(4), .PC_W(4), .IRQ_VEC(32'hC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .irq       (irq),
        .irq_ack   (irq_ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .flags     (flags),
        .halted    (halted)
    );

    assign imem_data = rom[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] insn(input logic [3:0] op, input logic [1:0] r, input logic [3:0] imm);
        return {op, r, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 16; i++) rom[i] = 10'h0;
    endtask

    // Asynchronous reset mid-cycle, check reset values, release on a falling edge
    task automatic reset_dut(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_rst_addr"},   32'(imem_addr), 32'h0);
        check({tag, "_rst_flags"},  32'(flags),     32'h0);
        check({tag, "_rst_out"},    32'(out_data),  32'h0);
        check({tag, "_rst_valid"},  32'(out_valid), 32'h0);
        check({tag, "_rst_ack"},    32'(irq_ack),   32'h0);
        check({tag, "_rst_halted"}, 32'(halted),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard: every OUT pulse must match the next expected value
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_out", 32'(out_valid), 32'h0);
            end else begin
                sb_exp = sb.pop_front();
                check("sb_out_data", 32'(out_data), 32'(sb_exp));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        irq   = 1'b0;
        rom_clear();

        // ADD with carry out, then OUT: 9+9 -> 2, C=1
        rom[0] = insn(4'h1, 2'd0, 4'd9);
        rom[1] = insn(4'h2, 2'd0, 4'd9);
        rom[2] = insn(4'hC, 2'd0, 4'd0);
        rom[3] = insn(4'hF, 2'd0, 4'd0);
        sb.push_back(4'h2);
        reset_dut("t1");
        cyc(5);
        check("t1_valid_c5", 32'(out_valid), 32'h0);
        cyc(1);
        check("t1_valid_c6", 32'(out_valid), 32'h1);
        check("t1_out_c6",   32'(out_data),  32'h2);
        check("t1_flags",    32'(flags),     32'b0010);
        cyc(1);
        check("t1_valid_c7", 32'(out_valid), 32'h0);
        cyc(1);
        check("t1_halted",   32'(halted),    32'h1);
        check("t1_hlt_addr", 32'(imem_addr), 32'h3);
        cyc(20);
        check("t1_halted20", 32'(halted),    32'h1);
        check("t1_frozen20", 32'(imem_addr), 32'h3);

        // SUB to zero, JC not taken, JZ taken; then 3-4 -> F with borrow
        rom_clear();
        rom[0]  = insn(4'h1, 2'd1, 4'd3);
        rom[1]  = insn(4'h3, 2'd1, 4'd3);
        rom[2]  = insn(4'hB, 2'd0, 4'h5);
        rom[3]  = insn(4'hA, 2'd0, 4'hA);
        rom[10] = insn(4'h1, 2'd1, 4'd3);
        rom[11] = insn(4'h3, 2'd1, 4'd4);
        rom[12] = insn(4'hC, 2'd1, 4'd0);
        rom[13] = insn(4'hF, 2'd0, 4'd0);
        sb.push_back(4'hF);
        reset_dut("t2");
        cyc(4);
        check("t2_flags_zero", 32'(flags),     32'b0001);
        cyc(2);
        check("t2_jc_fall",    32'(imem_addr), 32'h3);
        cyc(2);
        check("t2_jz_taken",   32'(imem_addr), 32'hA);
        cyc(4);
        check("t2_flags_brw",  32'(flags),     32'b0110);
        cyc(2);
        check("t2_valid",      32'(out_valid), 32'h1);
        cyc(2);
        check("t2_halted",     32'(halted),    32'h1);
        check("t2_hlt_addr",   32'(imem_addr), 32'hD);

        // PC wrap F -> 0 keeps flags
        rom_clear();
        rom[0] = insn(4'h1, 2'd2, 4'd8);
        reset_dut("t3");
        cyc(2);
        check("t3_flags_n",  32'(flags),     32'b0100);
        cyc(28);
        check("t3_addr_f",   32'(imem_addr), 32'hF);
        cyc(2);
        check("t3_wrap",     32'(imem_addr), 32'h0);
        check("t3_flags_kp", 32'(flags),     32'b0100);

        // Interrupt: EI with irq already high, handler at C, RETI; then HLT wake-up
        rom_clear();
        rom[0]  = insn(4'h1, 2'd3, 4'd7);
        rom[1]  = insn(4'hD, 2'd0, 4'd1);
        rom[2]  = insn(4'h0, 2'd0, 4'd0);
        rom[3]  = insn(4'hC, 2'd3, 4'd0);
        rom[4]  = insn(4'hF, 2'd0, 4'd0);
        rom[12] = insn(4'h0, 2'd0, 4'd0);
        rom[13] = insn(4'hE, 2'd0, 4'd0);
        sb.push_back(4'h7);
        irq = 1'b1;
        reset_dut("t4");
`ifdef NBITPROC_IRQ_EN
        cyc(4);
        check("t4_ie_set",     32'(flags),     32'b1000);
        cyc(1);
        check("t4_no_ack_yet", 32'(irq_ack),   32'h0);
        cyc(1);
        check("t4_ack",        32'(irq_ack),   32'h1);
        check("t4_vec",        32'(imem_addr), 32'hC);
        check("t4_ie_clr",     32'(flags),     32'b0000);
        cyc(1);
        check("t4_ack_pulse",  32'(irq_ack),   32'h0);
        cyc(3);
        check("t4_reti_addr",  32'(imem_addr), 32'h2);
        check("t4_reti_ie",    32'(flags),     32'b1000);
        irq = 1'b0;
        cyc(4);
        check("t4_out_valid",  32'(out_valid), 32'h1);
        cyc(2);
        check("t4_halted",     32'(halted),    32'h1);
        check("t4_hlt_addr",   32'(imem_addr), 32'h4);
        cyc(20);
        check("t4_halted20",   32'(halted),    32'h1);
        check("t4_frozen20",   32'(imem_addr), 32'h4);
        irq = 1'b1;
        cyc(1);
        check("t4_wake",       32'(halted),    32'h0);
        cyc(1);
        check("t4_hlt_ack",    32'(irq_ack),   32'h1);
        check("t4_hlt_vec",    32'(imem_addr), 32'hC);
        irq = 1'b0;
        cyc(4);
        check("t4_resume",     32'(imem_addr), 32'h5);
        check("t4_resume_ie",  32'(flags),     32'b1000);
`else
        cyc(4);
        check("t4_ie_zero",    32'(flags),     32'b0000);
        check("t4_addr2",      32'(imem_addr), 32'h2);
        cyc(2);
        check("t4_no_irq",     32'(imem_addr), 32'h3);
        check("t4_no_ack",     32'(irq_ack),   32'h0);
        cyc(2);
        check("t4_out_valid",  32'(out_valid), 32'h1);
        cyc(2);
        check("t4_halted",     32'(halted),    32'h1);
        cyc(20);
        check("t4_halted20",   32'(halted),    32'h1);
        check("t4_frozen20",   32'(imem_addr), 32'h4);
        check("t4_no_ack20",   32'(irq_ack),   32'h0);
        irq = 1'b0;
`endif

        // Reset while ADD is in EXEC: no partial effect, accumulators cleared
        rom_clear();
        rom[0] = insn(4'h1, 2'd0, 4'd5);
        rom[1] = insn(4'hC, 2'd0, 4'd0);
        rom[2] = insn(4'h2, 2'd0, 4'd1);
        rom[3] = insn(4'hF, 2'd0, 4'd0);
        sb.push_back(4'h5);
        reset_dut("t5");
        cyc(4);
        check("t5_out5", 32'(out_data), 32'h5);
        cyc(1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_out",   32'(out_data),  32'h0);
        check("t5_async_flags", 32'(flags),     32'h0);
        check("t5_async_addr",  32'(imem_addr), 32'h0);
        check("t5_async_valid", 32'(out_valid), 32'h0);
        rom_clear();
        rom[0] = insn(4'hC, 2'd0, 4'd0);
        rom[1] = insn(4'hF, 2'd0, 4'd0);
        sb.push_back(4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        check("t5_first_fetch", 32'(imem_addr), 32'h0);
        cyc(1);
        check("t5_valid",       32'(out_valid), 32'h1);
        cyc(2);
        check("t5_sb_empty",    32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
